// File: rtl/xpb_lut_pkg.sv
// Shared types and helpers for the runtime-loadable reduction-constant table.
package xpb_lut_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOADING = 2'd1,
    ST_READY   = 2'd2
  } lut_state_e;

  localparam int unsigned DEFAULT_IDX_BITS = 5;
  localparam int unsigned DEPTH            = 2**DEFAULT_IDX_BITS;

  function automatic int unsigned ch_off(input int unsigned ch, input int unsigned width);
    return ch * width;
  endfunction

endpackage

// File: rtl/xpb_lut_bank.sv
// Table storage: entries 1..DEPTH-1 in registers, entry 0 decodes to zero.
module xpb_lut_bank
  import xpb_lut_pkg::*;
#(
  parameter int unsigned IDX_BITS  = DEFAULT_IDX_BITS,
  parameter int unsigned DATA_BITS = 1024,
  parameter int unsigned NUM_CH    = 1
) (
  input  logic                          clk,
  input  logic                          we_i,
  input  logic [IDX_BITS-1:0]           waddr_i,
  input  logic [DATA_BITS-1:0]          wdata_i,
  input  logic [NUM_CH*IDX_BITS-1:0]    rd_idx_i,
  output logic [NUM_CH*DATA_BITS-1:0]   rd_data_o
);

  localparam int unsigned LAST = 2**IDX_BITS - 1;

  logic [DATA_BITS-1:0] mem_q [1:LAST];

  always_ff @(posedge clk) begin
    if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    logic [IDX_BITS-1:0] idx;
    idx       = '0;
    rd_data_o = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      idx = rd_idx_i[ch_off(c, IDX_BITS) +: IDX_BITS];
      if (idx != '0) begin
        rd_data_o[ch_off(c, DATA_BITS) +: DATA_BITS] = mem_q[idx];
      end
    end
  end

endmodule

// File: rtl/xpb_lut_ram.sv
// Streaming-loadable multi-channel constant table with RD_LAT-cycle lookups.
//   state      | meaning
//   ST_IDLE    | no valid table since reset, waiting for load_start
//   ST_LOADING | accepting beats for entries 1..DEPTH-1
//   ST_READY   | table complete, lookups return data
module xpb_lut_ram
  import xpb_lut_pkg::*;
#(
  parameter int unsigned IDX_BITS  = DEFAULT_IDX_BITS,
  parameter int unsigned DATA_BITS = 1024,
  parameter int unsigned NUM_CH    = 1,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load_start,
  input  logic                          load_valid,
  input  logic [DATA_BITS-1:0]          load_data,
  output logic                          load_ready,
  output logic                          table_ready,
  input  logic [NUM_CH-1:0]             lookup_valid,
  input  logic [NUM_CH*IDX_BITS-1:0]    lookup_idx,
  output logic [NUM_CH-1:0]             result_valid,
  output logic [NUM_CH*DATA_BITS-1:0]   result_data,
  output logic [NUM_CH-1:0]             result_err
);

  lut_state_e                state_q, state_d;
  logic [IDX_BITS-1:0]       cnt_q, cnt_d;
  logic                      beat;

  // A beat coinciding with load_start is dropped: the restart wins.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat    = 1'b0;
    if (load_start) begin
      state_d = ST_LOADING;
      cnt_d   = IDX_BITS'(1);
    end else if ((state_q == ST_LOADING) && load_valid) begin
      beat  = 1'b1;
      cnt_d = cnt_q + IDX_BITS'(1);
      if (cnt_q == '1) begin
        state_d = ST_READY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign load_ready  = (state_q == ST_LOADING);
  assign table_ready = (state_q == ST_READY);

  logic [NUM_CH-1:0]           iss_vld;
  logic                        iss_ok;
  logic [NUM_CH*IDX_BITS-1:0]  iss_idx;

  generate
    if (RD_LAT == 2) begin : g_stage
      logic [NUM_CH-1:0]          vld_q;
      logic                       ok_q;
      logic [NUM_CH*IDX_BITS-1:0] idx_q;
      always_ff @(posedge clk) begin
        if (reset) begin
          vld_q <= '0;
          ok_q  <= 1'b0;
          idx_q <= '0;
        end else begin
          vld_q <= lookup_valid;
          ok_q  <= table_ready;
          idx_q <= lookup_idx;
        end
      end
      assign iss_vld = vld_q;
      assign iss_ok  = ok_q;
      assign iss_idx = idx_q;
    end else begin : g_direct
      assign iss_vld = lookup_valid;
      assign iss_ok  = table_ready;
      assign iss_idx = lookup_idx;
    end
  endgenerate

  logic [NUM_CH*DATA_BITS-1:0] rd_data;

  xpb_lut_bank #(
    .IDX_BITS  (IDX_BITS),
    .DATA_BITS (DATA_BITS),
    .NUM_CH    (NUM_CH)
  ) u_bank (
    .clk       (clk),
    .we_i      (beat),
    .waddr_i   (cnt_q),
    .wdata_i   (load_data),
    .rd_idx_i  (iss_idx),
    .rd_data_o (rd_data)
  );

  logic [NUM_CH-1:0]           res_valid_q;
  logic [NUM_CH-1:0]           res_err_q;
  logic [NUM_CH*DATA_BITS-1:0] res_data_q, res_data_d;

  always_comb begin
    res_data_d = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (iss_vld[c] && iss_ok) begin
        res_data_d[ch_off(c, DATA_BITS) +: DATA_BITS] = rd_data[ch_off(c, DATA_BITS) +: DATA_BITS];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid_q <= '0;
      res_err_q   <= '0;
      res_data_q  <= '0;
    end else begin
      res_valid_q <= iss_vld;
      res_err_q   <= iss_vld & {NUM_CH{~iss_ok}};
      res_data_q  <= res_data_d;
    end
  end

  assign result_valid = res_valid_q;
  assign result_err   = res_err_q;
  assign result_data  = res_data_q;

endmodule

// File: tb/tb_xpb_lut_ram.sv
// Randomised bench for xpb_lut_ram: two instances (RD_LAT 1 and 2) against a table model.
module tb_xpb_lut_ram;

  localparam int IB = 5;
  localparam int DB = 1024;
  localparam int NC = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              load_start, load_valid;
  logic [DB-1:0]     load_data;
  logic [NC-1:0]     lookup_valid;
  logic [NC*IB-1:0]  lookup_idx;

  logic              lr1, tr1, lr2, tr2;
  logic [NC-1:0]     rv1, re1, rv2, re2;
  logic [NC*DB-1:0]  rd1, rd2;

  always #5 clk = ~clk;

  xpb_lut_ram #(.IDX_BITS(IB), .DATA_BITS(DB), .NUM_CH(NC), .RD_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_ready(lr1), .table_ready(tr1),
    .lookup_valid(lookup_valid), .lookup_idx(lookup_idx),
    .result_valid(rv1), .result_data(rd1), .result_err(re1));

  xpb_lut_ram #(.IDX_BITS(IB), .DATA_BITS(DB), .NUM_CH(NC), .RD_LAT(2)) dut2 (
    .clk(clk), .reset(reset), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_ready(lr2), .table_ready(tr2),
    .lookup_valid(lookup_valid), .lookup_idx(lookup_idx),
    .result_valid(rv2), .result_data(rd2), .result_err(re2));

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 0;
  bit rnd_en = 0;

  function automatic logic [DB-1:0] E(input int i);
    logic [DB-1:0] r;
    r = DB'(i);
    r = (r << 1000) | DB'(i);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_d(input string nm, input logic [DB-1:0] act, input logic [DB-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got hi=%h lo=%h expected hi=%h lo=%h",
               nm, act[DB-1:DB-64], act[63:0], exp[DB-1:DB-64], exp[63:0]);
    end
  endtask

  // Behavioural model: table contents, load progress, and results by issue age.
  typedef struct packed {
    logic [NC-1:0]    v;
    logic [NC-1:0]    e;
    logic [NC*DB-1:0] d;
  } rec_t;

  logic [DB-1:0] m_mem [32];
  bit            m_ready   = 0;
  bit            m_loading = 0;
  int            m_next    = 1;
  rec_t          h1 = '0, h2 = '0, cur;

  always @(posedge clk) begin
    int idx;
    cur = '0;
    for (int c = 0; c < NC; c++) begin
      if (lookup_valid[c]) begin
        cur.v[c] = 1'b1;
        if (m_ready) begin
          idx = int'(lookup_idx[c*IB +: IB]);
          cur.d[c*DB +: DB] = (idx == 0) ? '0 : m_mem[idx];
        end else begin
          cur.e[c] = 1'b1;
        end
      end
    end
    h2 = h1;
    h1 = cur;
    if (reset) begin
      h1 = '0; h2 = '0;
      m_ready = 0; m_loading = 0;
    end else if (load_start) begin
      m_loading = 1; m_ready = 0; m_next = 1;
    end else if (m_loading && load_valid) begin
      m_mem[m_next] = load_data;
      if (m_next == 31) begin
        m_loading = 0; m_ready = 1;
      end
      m_next++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("lat1_load_ready", 64'(lr1), 64'(m_loading));
      chk("lat1_table_ready", 64'(tr1), 64'(m_ready));
      chk("lat1_valid", 64'(rv1), 64'(h1.v));
      chk("lat1_err", 64'(re1), 64'(h1.e));
      chk_d("lat1_data_ch0", rd1[DB-1:0], h1.d[DB-1:0]);
      chk_d("lat1_data_ch1", rd1[2*DB-1:DB], h1.d[2*DB-1:DB]);
      chk("lat2_load_ready", 64'(lr2), 64'(m_loading));
      chk("lat2_table_ready", 64'(tr2), 64'(m_ready));
      chk("lat2_valid", 64'(rv2), 64'(h2.v));
      chk("lat2_err", 64'(re2), 64'(h2.e));
      chk_d("lat2_data_ch0", rd2[DB-1:0], h2.d[DB-1:0]);
      chk_d("lat2_data_ch1", rd2[2*DB-1:DB], h2.d[2*DB-1:DB]);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic rand_lk();
    if (rnd_en) begin
      lookup_valid = NC'($urandom);
      lookup_idx   = (NC*IB)'($urandom);
    end else begin
      lookup_valid = '0;
      lookup_idx   = '0;
    end
  endtask

  // mode: 0 = E(i), 1 = ~E(i), 2 = random data
  task automatic load_table(input int mode, input int n_beats, input bit gap);
    int k;
    int cyc;
    load_start = 1'b1; load_valid = 1'b0;
    rand_lk();
    step();
    load_start = 1'b0;
    k = 1; cyc = 0;
    while (k <= n_beats) begin
      cyc++;
      load_valid = !(gap && (cyc % 3 == 0));
      case (mode)
        0: load_data = E(k);
        1: load_data = ~E(k);
        default: for (int w = 0; w < DB/32; w++) load_data[w*32 +: 32] = $urandom;
      endcase
      rand_lk();
      if (k == 31 && load_valid) chk("table_ready_before_last", 64'(tr1), 64'd0);
      step();
      if (load_valid) k++;
    end
    load_valid = 1'b0;
    rand_lk();
    if (n_beats == 31) begin
      chk("table_ready_after_last", 64'(tr1), 64'd1);
      chk("load_ready_after_last", 64'(lr1), 64'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_data = '0;
    lookup_valid = '0; lookup_idx = '0;
    repeat (3) step();
    chk_en = 1;
    reset = 1'b0;
    step();
    chk("reset_load_ready", 64'(lr1), 64'd0);
    chk("reset_table_ready", 64'(tr1), 64'd0);
    chk("reset_valid", 64'(rv1), 64'd0);

    // lookup before any load
    lookup_valid = 2'b01; lookup_idx = {5'd0, 5'd3};
    step();
    lookup_valid = '0;
    chk("preload_valid", 64'(rv1), 64'h1);
    chk("preload_err", 64'(re1), 64'h1);
    chk_d("preload_data", rd1[DB-1:0], '0);
    chk("preload_table_ready", 64'(tr1), 64'd0);

    rnd_en = 1;
    load_table(0, 31, 1);
    rnd_en = 0;
    rand_lk();

    // dual-channel read
    lookup_valid = 2'b11; lookup_idx = {5'd31, 5'd0};
    step();
    chk_d("dual_ch0_idx0", rd1[DB-1:0], '0);
    chk_d("dual_ch1_idx31", rd1[2*DB-1:DB], E(31));
    chk("dual_err", 64'(re1), 64'h0);
    lookup_idx = {5'd7, 5'd7};
    step();
    lookup_valid = '0;
    chk_d("dup_ch0_idx7", rd1[DB-1:0], E(7));
    chk_d("dup_ch1_idx7", rd1[2*DB-1:DB], E(7));

    // restart mid-load
    load_table(0, 10, 0);
    lookup_valid = 2'b01; lookup_idx = {5'd0, 5'd4};
    step();
    lookup_valid = '0;
    chk("midload_err", 64'(re1), 64'h1);
    rnd_en = 1;
    load_table(1, 31, 0);
    rnd_en = 0;
    rand_lk();
    lookup_valid = 2'b01; lookup_idx = {5'd0, 5'd5};
    step();
    lookup_valid = '0;
    chk_d("restart_idx5", rd1[DB-1:0], ~E(5));

    // reset mid-load
    load_table(0, 20, 0);
    reset = 1'b1;
    step();
    chk("rst_mid_load_ready", 64'(lr1), 64'd0);
    chk("rst_mid_table_ready", 64'(tr1), 64'd0);
    reset = 1'b0;
    load_table(0, 31, 1);

    // RD_LAT=2 streaming
    for (int i = 0; i < 34; i++) begin
      if (i < 32) begin
        lookup_valid = 2'b11;
        lookup_idx   = {5'(i), 5'(i)};
      end else begin
        lookup_valid = '0;
      end
      step();
      if (i >= 1 && i <= 32) begin
        chk("stream_valid", 64'(rv2), 64'h3);
        chk_d("stream_ch0", rd2[DB-1:0], E(i-1));
        chk_d("stream_ch1", rd2[2*DB-1:DB], E(i-1));
      end
    end

    // random soak
    rnd_en = 1;
    load_table(2, 31, 1);
    for (int n = 0; n < 500; n++) begin
      reset      = ($urandom_range(0, 199) == 0);
      load_start = ($urandom_range(0, 79) == 0);
      load_valid = ($urandom_range(0, 3) != 0);
      for (int w = 0; w < DB/32; w++) load_data[w*32 +: 32] = $urandom;
      rand_lk();
      step();
    end
    reset = 1'b0; load_start = 1'b0; load_valid = 1'b0;
    rnd_en = 0;
    rand_lk();
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
